alu_scheduler: RTL

Two-port scheduler that shares the single combinational ALU between the control unit (port 0) and a secondary requester (port 1, e.g. an address/loop unit). It arbitrates round-robin, latches the winner's operation and operands, drives the ALU's `ALU_Operation`/`AC`/`Bus` inputs for one settle cycle, and registers the result and a zero flag. The result is held for the owning requester under a valid/ready response handshake.

---
 rtl/alu_scheduler.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/alu_scheduler.sv
// ---------------------------------------------------------------------------
// alu_scheduler
//   Shares one combinational ALU between two requesters. Port 0 is the
//   control unit and port 1 is a secondary requester such as an address or
//   loop unit. The block picks one request round-robin and latches it. It
//   drives the ALU for one settle cycle, then registers the result and a
//   zero flag. The response is held for the owning port until that port
//   takes it through a valid/ready handshake.
//
// Ports
//   clk, reset                 rising-edge clock, async active-low reset
//   reqN_valid/ready           request handshake (ready is combinational)
//   reqN_op/a/b                op code, AC operand, Bus operand
//   rspN_valid/ready           response handshake for port N
//   rspN_result/z/err          shared result registers (valid with rspN_valid)
//   alu_op/alu_ac/alu_bus      drive the ALU ALU_Operation / AC / Bus inputs
//   alu_result                 ALU result input
// ---------------------------------------------------------------------------
module alu_scheduler #(
    parameter int reg_width = 12
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [2:0]           req0_op,
    input  logic [reg_width-1:0] req0_a,
    input  logic [reg_width-1:0] req0_b,
    output logic                 rsp0_valid,
    input  logic                 rsp0_ready,
    output logic [reg_width-1:0] rsp0_result,
    output logic                 rsp0_z,
    output logic                 rsp0_err,

    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [2:0]           req1_op,
    input  logic [reg_width-1:0] req1_a,
    input  logic [reg_width-1:0] req1_b,
    output logic                 rsp1_valid,
    input  logic                 rsp1_ready,
    output logic [reg_width-1:0] rsp1_result,
    output logic                 rsp1_z,
    output logic                 rsp1_err,

    output logic [2:0]           alu_op,
    output logic [reg_width-1:0] alu_ac,
    output logic [reg_width-1:0] alu_bus,
    input  logic [reg_width-1:0] alu_result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [2:0] OP_IDLE = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_BAD  = 3'b111;

    // IDLE and the reserved code both come back as an error.
    function automatic logic is_err_op(input logic [2:0] op);
        return (op == OP_IDLE) || (op == OP_BAD);
    endfunction

    // Error ops report zero no matter what the ALU produced while idling.
    function automatic logic [reg_width-1:0] fit_result(
        input logic [reg_width-1:0] res,
        input logic                 err
    );
        return err ? '0 : res;
    endfunction

    // The zero flag is defined only for Sub. The ALU's own Zflag is ignored.
    function automatic logic zero_flag(
        input logic [2:0]           op,
        input logic [reg_width-1:0] res
    );
        return (op == OP_SUB) && (res == '0);
    endfunction

    state_t                 state;
    logic                   prio;
    logic                   owner;
    logic [2:0]             op_p0;
    logic                   err_p0;
    logic [reg_width-1:0]   result_p1;
    logic                   z_p1;
    logic                   err_p1;
    logic                   rsp0_valid_q;
    logic                   rsp1_valid_q;
    logic [reg_width-1:0]   res_fit;

    logic                   grant0;
    logic                   grant1;
    logic                   handshake;

    // Round-robin: a lone valid port wins, and on contention prio decides.
    assign grant0 = req0_valid && (!req1_valid || !prio);
    assign grant1 = req1_valid && (!req0_valid || prio);

    // Qualifying with reset keeps ready low while reset is held.
    assign req0_ready = (state == S_IDLE) && reset && grant0;
    assign req1_ready = (state == S_IDLE) && reset && grant1;

    assign handshake = (rsp0_valid_q && rsp0_ready) || (rsp1_valid_q && rsp1_ready);

    assign res_fit = fit_result(alu_result, err_p0);

    assign rsp0_valid  = rsp0_valid_q;
    assign rsp1_valid  = rsp1_valid_q;
    assign rsp0_result = result_p1;
    assign rsp1_result = result_p1;
    assign rsp0_z      = z_p1;
    assign rsp1_z      = z_p1;
    assign rsp0_err    = err_p1;
    assign rsp1_err    = err_p1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            prio         <= 1'b0;
            owner        <= 1'b0;
            op_p0        <= OP_IDLE;
            err_p0       <= 1'b0;
            result_p1    <= '0;
            z_p1         <= 1'b0;
            err_p1       <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            alu_op       <= OP_IDLE;
            alu_ac       <= '0;
            alu_bus      <= '0;
        end else begin
            case (state)
                // Accept stage: latch the winner and present it to the ALU.
                S_IDLE: begin
                    if (req0_ready || req1_ready) begin
                        owner <= grant1;
                        prio  <= grant0;
                        state <= S_EXEC;
                        if (grant1) begin
                            op_p0   <= req1_op;
                            err_p0  <= is_err_op(req1_op);
                            alu_op  <= is_err_op(req1_op) ? OP_IDLE : req1_op;
                            alu_ac  <= req1_a;
                            alu_bus <= req1_b;
                        end else begin
                            op_p0   <= req0_op;
                            err_p0  <= is_err_op(req0_op);
                            alu_op  <= is_err_op(req0_op) ? OP_IDLE : req0_op;
                            alu_ac  <= req0_a;
                            alu_bus <= req0_b;
                        end
                    end
                end
                // Execute stage: the ALU settles for a cycle, then the result is captured.
                S_EXEC: begin
                    result_p1    <= res_fit;
                    z_p1         <= zero_flag(op_p0, res_fit);
                    err_p1       <= err_p0;
                    alu_op       <= OP_IDLE;
                    alu_ac       <= '0;
                    alu_bus      <= '0;
                    rsp0_valid_q <= !owner;
                    rsp1_valid_q <= owner;
                    state        <= S_RESP;
                end
                // Response stage: hold the result until the owner takes it.
                S_RESP: begin
                    if (handshake) begin
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
